// File: rtl/vector_store_sequencer.sv
// Serialises one captured vector into LANES byte writes, one lane per cycle, then pulses done.
// Optional per-lane write masking is enabled by defining VSTORE_LANE_MASK_EN.
module vector_store_sequencer #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [LANES*LANE_W-1:0]   vector_data_in,
  input  logic [ADDR_W-1:0]         base_address,
`ifdef VSTORE_LANE_MASK_EN
  input  logic [LANES-1:0]          lane_mask,
`endif
  output logic [ADDR_W-1:0]         mem_address,
  output logic [LANE_W-1:0]         mem_data,
  output logic                      mem_wren,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned LaneIdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LaneIdxW-1:0] LastLane = LaneIdxW'(LANES - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                    state_q, state_d;
  logic [LaneIdxW-1:0]       lane_q, lane_d;
  logic [LANES*LANE_W-1:0]   vec_q, vec_d;
  logic [ADDR_W-1:0]         base_q, base_d;
`ifdef VSTORE_LANE_MASK_EN
  logic [LANES-1:0]          mask_q, mask_d;
`endif

  logic [ADDR_W-1:0]         mem_address_q, mem_address_d;
  logic [LANE_W-1:0]         mem_data_q, mem_data_d;
  logic                      mem_wren_q, mem_wren_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      start_ready_q, start_ready_d;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    vec_d   = vec_q;
    base_d  = base_q;
`ifdef VSTORE_LANE_MASK_EN
    mask_d  = mask_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_valid && start_ready_q) begin
          vec_d   = vector_data_in;
          base_d  = base_address;
`ifdef VSTORE_LANE_MASK_EN
          mask_d  = lane_mask;
`endif
          lane_d  = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (lane_q == LastLane) begin
          state_d = StDone;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so no input reaches a port
  // combinationally; the captured copies (vec_d/base_d) only differ from inputs at acceptance.
  always_comb begin
    start_ready_d = (state_d == StIdle);
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
    mem_wren_d    = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    if (state_d == StWrite) begin
      mem_address_d = base_d + ADDR_W'(lane_d);
      mem_data_d    = vec_d[lane_d*LANE_W +: LANE_W];
`ifdef VSTORE_LANE_MASK_EN
      mem_wren_d    = mask_d[lane_d];
`else
      mem_wren_d    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      lane_q        <= '0;
      vec_q         <= '0;
      base_q        <= '0;
`ifdef VSTORE_LANE_MASK_EN
      mask_q        <= '0;
`endif
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      vec_q         <= vec_d;
      base_q        <= base_d;
`ifdef VSTORE_LANE_MASK_EN
      mask_q        <= mask_d;
`endif
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign start_ready = start_ready_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_vector_store_sequencer.sv
// Randomized self-checking bench: each accepted store is expanded into its expected per-cycle
// write stream (address = base + lane mod 2^ADDR_W) and compared cycle by cycle.
module tb_vector_store_sequencer;

  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int ADDR_W = 12;
`ifdef VSTORE_LANE_MASK_EN
  localparam bit MaskEn = 1'b1;
`else
  localparam bit MaskEn = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start_valid;
  logic                    start_ready;
  logic [LANES*LANE_W-1:0] vector_data_in;
  logic [ADDR_W-1:0]       base_address;
`ifdef VSTORE_LANE_MASK_EN
  logic [LANES-1:0]        lane_mask;
`endif
  logic [ADDR_W-1:0]       mem_address;
  logic [LANE_W-1:0]       mem_data;
  logic                    mem_wren;
  logic                    busy;
  logic                    done;

  int n_checks = 0;
  int n_pass   = 0;

  vector_store_sequencer #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .ADDR_W(ADDR_W)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .vector_data_in(vector_data_in),
    .base_address  (base_address),
`ifdef VSTORE_LANE_MASK_EN
    .lane_mask     (lane_mask),
`endif
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .mem_wren      (mem_wren),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [LANES*LANE_W-1:0] rand_vec();
    logic [LANES*LANE_W-1:0] v;
    for (int k = 0; k < LANES*LANE_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic scramble_inputs(input bit keep_valid);
    vector_data_in = rand_vec();
    base_address   = ADDR_W'($urandom);
    start_valid    = keep_valid ? 1'b1 : 1'(($urandom_range(0, 1)));
`ifdef VSTORE_LANE_MASK_EN
    lane_mask      = 16'($urandom);
`endif
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge of the first idle cycle after done.
  task automatic run_store(input string name, input logic [ADDR_W-1:0] base,
                           input logic [LANES*LANE_W-1:0] vec, input logic [LANES-1:0] mask,
                           input bit keep_valid);
    logic exp_wren;
    int   exp_addr;
    start_valid    = 1'b1;
    vector_data_in = vec;
    base_address   = base;
`ifdef VSTORE_LANE_MASK_EN
    lane_mask      = mask;
`endif
    check({name, " ready_before"}, 32'(start_ready), 32'd1);
    @(posedge clk);
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      exp_wren = MaskEn ? mask[i] : 1'b1;
      exp_addr = (int'(base) + i) % (1 << ADDR_W);
      check($sformatf("%s wren[%0d]", name, i), 32'(mem_wren), 32'(exp_wren));
      check($sformatf("%s busy[%0d]", name, i), 32'(busy), 32'd1);
      check($sformatf("%s ready[%0d]", name, i), 32'(start_ready), 32'd0);
      check($sformatf("%s done[%0d]", name, i), 32'(done), 32'd0);
      if (exp_wren) begin
        check($sformatf("%s addr[%0d]", name, i), 32'(mem_address), 32'(exp_addr));
        check($sformatf("%s data[%0d]", name, i), 32'(mem_data), 32'(vec[i*LANE_W +: LANE_W]));
      end
      scramble_inputs(keep_valid);
    end
    @(negedge clk);
    check({name, " done_pulse"}, 32'(done), 32'd1);
    check({name, " done_wren"}, 32'(mem_wren), 32'd0);
    check({name, " done_busy"}, 32'(busy), 32'd1);
    check({name, " done_ready"}, 32'(start_ready), 32'd0);
    @(negedge clk);
    check({name, " idle_done"}, 32'(done), 32'd0);
    check({name, " idle_busy"}, 32'(busy), 32'd0);
    check({name, " idle_ready"}, 32'(start_ready), 32'd1);
    check({name, " idle_wren"}, 32'(mem_wren), 32'd0);
    start_valid = 1'b0;
  endtask

  initial begin
    logic [LANES*LANE_W-1:0] v;
    logic [LANES-1:0]        m;

    reset          = 1'b0;
    start_valid    = 1'b0;
    vector_data_in = '0;
    base_address   = '0;
`ifdef VSTORE_LANE_MASK_EN
    lane_mask      = '0;
`endif
    #1 reset = 1'b1;
    #1;
    check("rst ready", 32'(start_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst wren", 32'(mem_wren), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst addr", 32'(mem_address), 32'd0);
    check("rst data", 32'(mem_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed store: lane i carries i+0xA0, base 0x100.
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = LANE_W'(i + 'hA0);
    run_store("base100", 12'h100, v, 16'hFFFF, 1'b0);

    // Address wrap past the top of the address space.
    run_store("wrap", 12'hFFE, rand_vec(), 16'hFFFF, 1'b0);

    run_store("mask00ff", 12'h040, rand_vec(), 16'h00FF, 1'b0);

    // Back-to-back with start_valid held high throughout.
    run_store("hold_a", 12'h200, rand_vec(), 16'hFFFF, 1'b1);
    run_store("hold_b", 12'h300, rand_vec(), 16'hFFFF, 1'b1);

    for (int t = 0; t < 6; t++) begin
      m = MaskEn ? 16'($urandom) : 16'hFFFF;
      run_store($sformatf("rand%0d", t), ADDR_W'($urandom), rand_vec(), m, 1'($urandom_range(0, 1)));
    end

    // Abort a store at lane 5 with an asynchronous reset.
    start_valid    = 1'b1;
    v              = rand_vec();
    vector_data_in = v;
    base_address   = 12'h500;
`ifdef VSTORE_LANE_MASK_EN
    lane_mask      = 16'hFFFF;
`endif
    @(posedge clk);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      start_valid = 1'b0;
    end
    check("abort lane5 addr", 32'(mem_address), 32'h505);
    check("abort lane5 wren", 32'(mem_wren), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort wren", 32'(mem_wren), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(start_ready), 32'd1);
    check("abort addr", 32'(mem_address), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("post_abort done[%0d]", i), 32'(done), 32'd0);
      check($sformatf("post_abort wren[%0d]", i), 32'(mem_wren), 32'd0);
    end
    run_store("after_abort", 12'h0F0, rand_vec(), 16'hFFFF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
